// File: rtl/lsu_unit.sv
// Load/store unit: turns an ALU effective address plus rs2 into one req/gnt/rvalid
// data-memory transaction and returns aligned, extended load data for writeback.
module lsu_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_misalign,
  output logic        err_access,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 2);
  // The last WAIT cycle is the one where the counter would step onto TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic          bad_access;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;
  logic          timeout_hit;

  always_comb begin
    bad_access = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2])
               || (funct3[1:0] == 2'b01 && addr[0])
               || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << addr[1:0];
        wdata_calc = {2{store_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = store_data;
      end
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Every output is a register; done/err_* are set only on the edge entering RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      st_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_access   <= 1'b0;
      load_data    <= 32'h0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_be       <= 4'b0000;
      mem_wdata    <= 32'h0;
    end else begin
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_access   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            st_q      <= is_store;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            load_data <= 32'h0;
            busy      <= 1'b1;
            if (bad_access) begin
              state        <= S_RESP;
              done         <= 1'b1;
              err_misalign <= 1'b1;
            end else begin
              state     <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_calc;
              mem_wdata <= wdata_calc;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            cnt     <= '0;
            if (st_q) begin
              state <= S_RESP;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            load_data <= load_ext;
            state     <= S_RESP;
            done      <= 1'b1;
          end else if (timeout_hit) begin
            state      <= S_RESP;
            done       <= 1'b1;
            err_access <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
